// File: rtl/morph_pkg.sv
// Shared types for the iterative 3x3 binary morphology engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_DILATE = 2'b00,
        MODE_ERODE  = 2'b01,
        MODE_OPEN   = 2'b10,
        MODE_CLOSE  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        PH1,
        PH2,
        FIN
    } state_e;

    typedef enum logic {
        OP_DILATE = 1'b0,
        OP_ERODE  = 1'b1
    } op_e;

    // Structuring-element bit positions, named by compass direction from the pixel
    localparam int MASK_NW = 8;
    localparam int MASK_N  = 7;
    localparam int MASK_NE = 6;
    localparam int MASK_W  = 5;
    localparam int MASK_C  = 4;
    localparam int MASK_E  = 3;
    localparam int MASK_SW = 2;
    localparam int MASK_S  = 1;
    localparam int MASK_SE = 0;

    function automatic op_e first_op(input mode_e m);
        return (m == MODE_DILATE || m == MODE_CLOSE) ? OP_DILATE : OP_ERODE;
    endfunction

endpackage

// File: rtl/morph_iter_if.sv
// Request/result bundle between frame capture, morph_iter and the evaluator.
// Latency: n/a (wiring only); iter_count exists only with MORPH_CHANGE_DETECT_EN.
// Backpressure: none; start is only honoured while the engine is idle.
interface morph_iter_if #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int ITER_W = 4
);
    logic                      start;
    logic [1:0]                mode;
    logic [ITER_W-1:0]         iterations;
    logic [8:0]                mask;
    logic [WIDTH*HEIGHT-1:0]   image_in;
    logic                      busy;
    logic                      done;
    logic [WIDTH*HEIGHT-1:0]   image_out;
`ifdef MORPH_CHANGE_DETECT_EN
    logic [ITER_W:0]           iter_count;

    modport master (output start, mode, iterations, mask, image_in,
                    input  busy, done, image_out, iter_count);
    modport slave  (input  start, mode, iterations, mask, image_in,
                    output busy, done, image_out, iter_count);
`else
    modport master (output start, mode, iterations, mask, image_in,
                    input  busy, done, image_out);
    modport slave  (input  start, mode, iterations, mask, image_in,
                    output busy, done, image_out);
`endif
endinterface

// File: rtl/morph_pass.sv
// One 3x3 binary dilate/erode pass over a whole frame.
// Latency: purely combinational.
// Backpressure: none.
module morph_pass
    import morph_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) (
    input  logic [WIDTH*HEIGHT-1:0] frame,
    input  logic [8:0]              mask,
    input  op_e                     op,
    output logic [WIDTH*HEIGHT-1:0] frame_nxt
);

    // Out-of-frame neighbours read as the identity of the reduction: 0 for OR, 1 for AND
    logic pad;
    assign pad = (op == OP_ERODE);

    for (genvar l = 0; l < HEIGHT; l++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [8:0] nb;
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int NL = l + (MASK_NW - k) / 3 - 1;
                localparam int NC = c + (MASK_NW - k) % 3 - 1;
                if (NL < 0 || NL >= HEIGHT || NC < 0 || NC >= WIDTH) begin : g_pad
                    assign nb[k] = pad;
                end else begin : g_in
                    assign nb[k] = frame[NL*WIDTH + NC];
                end
            end
            assign frame_nxt[l*WIDTH + c] = pad ? &(nb | ~mask) : |(nb & mask);
        end
    end

endmodule

// File: rtl/morph_iter.sv
// Iterative 3x3 morphology (dilate/erode/open/close), one pass per clock; MORPH_CHANGE_DETECT_EN adds early exit + iter_count.
// Latency: accept to done = N+1 cycles (single op), 2N+1 (open/close), 1 for N=0.
// Backpressure: start ignored while busy; done is a one-cycle pulse with no stall.
module morph_iter
    import morph_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int ITER_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    morph_iter_if.slave bus
);

    localparam int NPIX = WIDTH * HEIGHT;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [8:0]        mask_q, mask_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NPIX-1:0]   image_q, image_d, pass_out;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              phase_end;
    logic              single_phase;
    op_e               op;
`ifdef MORPH_CHANGE_DETECT_EN
    logic [ITER_W:0]   iter_count_q, iter_count_d;
`endif

    morph_pass #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pass (
        .frame     (image_q),
        .mask      (mask_q),
        .op        (op),
        .frame_nxt (pass_out)
    );

    always_comb begin
        op           = first_op(mode_q);
        if (state_q == PH2) op = (first_op(mode_q) == OP_DILATE) ? OP_ERODE : OP_DILATE;
        single_phase = (mode_q == MODE_DILATE) || (mode_q == MODE_ERODE);
        cnt_inc      = cnt_q + {{(ITER_W-1){1'b0}}, 1'b1};
        phase_end    = (cnt_inc == iter_q);
`ifdef MORPH_CHANGE_DETECT_EN
        // A pass that changes nothing is a fixed point; further passes are wasted
        if (pass_out == image_q) phase_end = 1'b1;
        iter_count_d = iter_count_q;
`endif
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        image_d = image_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    image_d = bus.image_in;
                    mode_d  = mode_e'(bus.mode);
                    mask_d  = bus.mask;
                    iter_d  = bus.iterations;
                    cnt_d   = '0;
                    state_d = (bus.iterations == '0) ? FIN : PH1;
`ifdef MORPH_CHANGE_DETECT_EN
                    iter_count_d = '0;
`endif
                end
            end
            PH1, PH2: begin
                image_d = pass_out;
                cnt_d   = cnt_inc;
`ifdef MORPH_CHANGE_DETECT_EN
                iter_count_d = iter_count_q + {{ITER_W{1'b0}}, 1'b1};
`endif
                if (phase_end) begin
                    if (state_q == PH1 && !single_phase) begin
                        cnt_d   = '0;
                        state_d = PH2;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_DILATE;
            mask_q  <= '0;
            iter_q  <= '0;
            cnt_q   <= '0;
            image_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MORPH_CHANGE_DETECT_EN
            iter_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            iter_q  <= iter_d;
            cnt_q   <= cnt_d;
            image_q <= image_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MORPH_CHANGE_DETECT_EN
            iter_count_q <= iter_count_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.image_out = image_q;
`ifdef MORPH_CHANGE_DETECT_EN
    assign bus.iter_count = iter_count_q;
`endif

endmodule
